// File: rtl/seg_scan_display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment note display.
// Holds the capture FSM state type, segment constants and the digit code table.
package seg_scan_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Segment pattern {dp,g,f,e,d,c,b,a} for a note code; 0 and 10..15 are blank.
  function automatic logic [7:0] seg_code(input logic [3:0] note);
    logic [7:0] pat;
    case (note)
      4'd1:    pat = 8'h06;
      4'd2:    pat = 8'h5B;
      4'd3:    pat = 8'h4F;
      4'd4:    pat = 8'h66;
      4'd5:    pat = 8'h6D;
      4'd6:    pat = 8'h7D;
      4'd7:    pat = 8'h07;
      4'd8:    pat = 8'h7F;
      4'd9:    pat = 8'h6F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_display_key_sync.sv
// Key input conditioning: per-bit 2-flop synchronizer, optionally followed by a
// stability debouncer when SEG_DEBOUNCE_EN is defined.
module seg_scan_display_key_sync #(
  parameter int NUM_KEYS     = 7,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] ks
);

  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;

  // Two-flop synchronizer for the asynchronous key levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SEG_DEBOUNCE_EN
  localparam int DCNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [NUM_KEYS-1:0] sync_p2;
  logic [NUM_KEYS-1:0] deb_q;
  logic [DCNT_W-1:0]   dcnt;

  // Accept a new synced level only after it has held steady DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p2 <= '0;
      deb_q   <= '0;
      dcnt    <= '0;
    end else begin
      sync_p2 <= sync_p1;
      if ((sync_p1 == deb_q) || (sync_p1 != sync_p2)) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_W'(DEBOUNCE_CYC - 1)) begin
        deb_q <= sync_p1;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign ks = deb_q;
`else
  assign ks = sync_p1;
`endif

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit time-multiplexed 7-segment driver showing a history of played notes.
// Optional key debouncing is enabled with the SEG_DEBOUNCE_EN macro.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int NUM_KEYS       = 7,
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DEBOUNCE_CYC   = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key,
  input  logic                  clr,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [3:0]            cur_note,
  output logic                  note_valid
);

  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   CNT_W = $clog2(SCAN_DIV);
  localparam logic INV   = (SEG_ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] ks;
  state_t              state, state_nxt;
  logic                capture, release_evt;
  logic [3:0]          note_nxt;
  logic [3:0]          hist [NUM_DIGITS];
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                scan_wrap;
  logic [7:0]          seg_r, seg_nxt;
  logic [NUM_DIGITS-1:0] dig_r, dig_nxt;

  seg_scan_display_key_sync #(
    .NUM_KEYS     (NUM_KEYS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .ks    (ks)
  );

  // Note code of the lowest-index pressed key (0 when none)
  always_comb begin
    note_nxt = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (ks[i]) note_nxt = 4'(i + 1);
    end
  end

  // Capture FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture FSM next state: one capture per press, ignore other keys while held
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: if (ks != '0) begin
        state_nxt = HELD;
        capture   = 1'b1;
      end
      HELD: if (ks == '0) begin
        state_nxt   = IDLE;
        release_evt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Note history shift register, current note and hold flag; clr beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= 4'd0;
      cur_note   <= 4'd0;
      note_valid <= 1'b0;
    end else begin
      if (capture)          note_valid <= 1'b1;
      else if (release_evt) note_valid <= 1'b0;
      if (clr) begin
        for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= 4'd0;
        cur_note <= 4'd0;
      end else if (capture) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0]  <= note_nxt;
        cur_note <= note_nxt;
      end
    end
  end

  // Next digit slot and the segment/strobe values it will present
  always_comb begin
    scan_wrap = (cnt == CNT_W'(SCAN_DIV - 1));
    idx_nxt   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    dig_nxt   = NUM_DIGITS'(1) << idx_nxt;
    seg_nxt   = seg_code(hist[idx_nxt]) |
                (((idx_nxt == '0) && note_valid) ? SEG_DP : SEG_BLANK);
  end

  // Prescaler, scan index and output registers; seg and dig switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      seg_r <= SEG_BLANK;
      dig_r <= NUM_DIGITS'(1);
    end else if (scan_wrap) begin
      cnt   <= '0;
      idx   <= idx_nxt;
      seg_r <= seg_nxt;
      dig_r <= dig_nxt;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign seg = seg_r ^ {8{INV}};
  assign dig = dig_r ^ {NUM_DIGITS{INV}};

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed testbench for seg_scan_display (SCAN_DIV=4, NUM_DIGITS=4).
module tb_seg_scan_display;

  localparam int NUM_KEYS   = 7;
  localparam int NUM_DIGITS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_KEYS-1:0]   key = '0;
  logic                  clr = 1'b0;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] dig;
  logic [3:0]            cur_note;
  logic                  note_valid;

  int checks   = 0;
  int failures = 0;

  seg_scan_display #(
    .NUM_KEYS       (NUM_KEYS),
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (0),
    .DEBOUNCE_CYC   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .clr        (clr),
    .seg        (seg),
    .dig        (dig),
    .cur_note   (cur_note),
    .note_valid (note_valid)
  );

  always #5 clk = ~clk;

  // Wait for a fresh slot of digit k to start; a missed slot counts as a failure
  task automatic wait_slot(input int k);
    logic [NUM_DIGITS-1:0] want;
    int n;
    want = NUM_DIGITS'(1) << k;
    n = 0;
    while (dig === want && n < 64) begin @(negedge clk); n++; end
    while (dig !== want && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL slot_timeout digit=%0d dig=%b", k, dig);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key = '0; clr = 1'b0;
    #12;
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
    checks++; if (dig !== 4'b0001) begin failures++; $display("FAIL reset_dig got=%b exp=0001", dig); end
    checks++; if (cur_note !== 4'd0) begin failures++; $display("FAIL reset_note got=%0d exp=0", cur_note); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", note_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press;
    key = 7'b0000100;
    @(negedge clk);
    checks++; if (cur_note !== 4'd0) begin failures++; $display("FAIL press_edge1 got=%0d exp=0", cur_note); end
    @(negedge clk);
    checks++; if (cur_note !== 4'd0) begin failures++; $display("FAIL press_edge2 got=%0d exp=0", cur_note); end
    @(negedge clk);
    checks++; if (cur_note !== 4'd3) begin failures++; $display("FAIL press_edge3_note got=%0d exp=3", cur_note); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL press_edge3_valid got=%b exp=1", note_valid); end
    wait_slot(0);
    checks++; if (seg !== 8'hCF) begin failures++; $display("FAIL press_dig0_dp got=%h exp=CF", seg); end
    wait_slot(1);
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL press_dig1_blank got=%h exp=00", seg); end
    key = '0;
    repeat (3) @(negedge clk);
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", note_valid); end
    wait_slot(0);
    checks++; if (seg !== 8'h4F) begin failures++; $display("FAIL release_dig0 got=%h exp=4F", seg); end
  endtask

  task automatic test_history;
    logic [7:0] exp_seg [4];
    exp_seg[0] = 8'h6D; exp_seg[1] = 8'h66; exp_seg[2] = 8'h4F; exp_seg[3] = 8'h5B;
    for (int n = 1; n <= 5; n++) begin
      key = 7'(1 << (n - 1));
      repeat (4) @(negedge clk);
      key = '0;
      repeat (4) @(negedge clk);
    end
    checks++; if (cur_note !== 4'd5) begin failures++; $display("FAIL hist_note got=%0d exp=5", cur_note); end
    for (int d = 0; d < 4; d++) begin
      wait_slot(d);
      checks++;
      if (seg !== exp_seg[d]) begin
        failures++; $display("FAIL hist_dig%0d got=%h exp=%h", d, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_held_ignore;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    key = 7'b1010000;
    repeat (4) @(negedge clk);
    checks++; if (cur_note !== 4'd5) begin failures++; $display("FAIL multi_note got=%0d exp=5", cur_note); end
    key = 7'b1010001;
    repeat (6) @(negedge clk);
    checks++; if (cur_note !== 4'd5) begin failures++; $display("FAIL held_note got=%0d exp=5", cur_note); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL held_valid got=%b exp=1", note_valid); end
    wait_slot(0);
    checks++; if (seg !== 8'hED) begin failures++; $display("FAIL held_dig0 got=%h exp=ED", seg); end
    wait_slot(1);
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL held_dig1 got=%h exp=00", seg); end
    key = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clr_capture;
    key = 7'b0000010;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (cur_note !== 4'd0) begin failures++; $display("FAIL clrcap_note got=%0d exp=0", cur_note); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL clrcap_valid got=%b exp=1", note_valid); end
    wait_slot(0);
    checks++; if (seg !== 8'h80) begin failures++; $display("FAIL clrcap_dig0 got=%h exp=80", seg); end
    wait_slot(1);
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL clrcap_dig1 got=%h exp=00", seg); end
    wait_slot(3);
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL clrcap_dig3 got=%h exp=00", seg); end
    key = '0;
    repeat (4) @(negedge clk);
  endtask

`ifdef SEG_DEBOUNCE_EN
  task automatic test_debounce;
    logic [3:0] before;
    before = cur_note;
    key = 7'b0000010;
    repeat (5) @(negedge clk);
    key = '0;
    repeat (30) @(negedge clk);
    checks++; if (cur_note !== before) begin failures++; $display("FAIL glitch_note got=%0d exp=%0d", cur_note, before); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", note_valid); end
    key = 7'b0000010;
    repeat (20) @(negedge clk);
    checks++; if (cur_note !== 4'd2) begin failures++; $display("FAIL deb_note got=%0d exp=2", cur_note); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL deb_valid got=%b exp=1", note_valid); end
    key = '0;
    repeat (30) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    key = 7'b0001000;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (seg !== 8'h00) begin failures++; $display("FAIL midrst_seg got=%h exp=00", seg); end
    checks++; if (dig !== 4'b0001) begin failures++; $display("FAIL midrst_dig got=%b exp=0001", dig); end
    checks++; if (cur_note !== 4'd0) begin failures++; $display("FAIL midrst_note got=%0d exp=0", cur_note); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", note_valid); end
    key = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_history();
    test_held_ignore();
    test_clr_capture();
`ifdef SEG_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
